// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: synchronizes, debounces and decodes a 7-segment bus and counts digit changes.
// Optional `SEG7_BLANK_EN adds the blank output for an all-off pattern.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       abcdefg,
  input  logic             clear,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid_pattern,
  output logic             new_digit,
  output logic [CNT_W-1:0] change_count
`ifdef SEG7_BLANK_EN
  ,
  output logic             blank
`endif
);
  localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] TOP = SW'(STABLE_CYCLES - 1);
  typedef enum logic {SETTLING, LOCKED} state_t;
  state_t state, state_nxt;
  logic [6:0] s1, s2, s3;
  logic [SW-1:0] cnt, cnt_nxt;
  logic same, lock, hit, strobe, is_blank;
  logic [3:0] val;
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (s2)
      7'b1111110: val = 4'h0;
      7'b0110000: val = 4'h1;
      7'b1101101: val = 4'h2;
      7'b1111001: val = 4'h3;
      7'b0110011: val = 4'h4;
      7'b1011011: val = 4'h5;
      7'b1011111: val = 4'h6;
      7'b1110000: val = 4'h7;
      7'b1111111: val = 4'h8;
      7'b1111011: val = 4'h9;
      7'b1110111: val = 4'hA;
      7'b0011111: val = 4'hB;
      7'b1001110: val = 4'hC;
      7'b0111101: val = 4'hD;
      7'b1001111: val = 4'hE;
      7'b1000111: val = 4'hF;
      default:    hit = 1'b0;
    endcase
  end
  // s3 is the previous synchronized sample; a lock fires once per stable run
  always_comb begin
    same = s2 == s3;
    cnt_nxt = !same ? '0 : (cnt == TOP ? cnt : cnt + 1'b1);
    lock = state == SETTLING && same && cnt_nxt == TOP;
    state_nxt = (clear || !same) ? SETTLING : (lock ? LOCKED : state);
    strobe = lock && !clear && hit && (!digit_valid || val != digit);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      cnt <= '0;
      state <= SETTLING;
      digit <= '0;
      digit_valid <= 1'b0;
      invalid_pattern <= 1'b0;
      new_digit <= 1'b0;
      change_count <= '0;
    end else begin
      s1 <= abcdefg;
      s2 <= s1;
      s3 <= s2;
      cnt <= clear ? '0 : cnt_nxt;
      state <= state_nxt;
      new_digit <= strobe;
      if (clear) begin
        digit <= '0;
        digit_valid <= 1'b0;
        invalid_pattern <= 1'b0;
        change_count <= '0;
      end else if (lock) begin
        digit_valid <= hit;
        invalid_pattern <= !hit && !is_blank;
        if (hit) digit <= val;
        if (strobe) change_count <= change_count + 1'b1;
      end
    end
  end
`ifdef SEG7_BLANK_EN
  assign is_blank = s2 == 7'b0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blank <= 1'b0;
    else if (clear) blank <= 1'b0;
    else if (lock) blank <= is_blank;
  end
`else
  assign is_blank = 1'b0;
`endif
endmodule
